// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: up to 16 software-written 32-bit control words for user logic,
// with optional shadow registers that are copied to the outputs together on a commit write.

module opb_register_bank_ppc2simulink_chk #(
  parameter int N = 4
) (
  input logic         clk,
  input logic         rst_n,
  input logic         xfer_ack,
  input logic         err_ack,
  input logic         commit,
  input logic [31:0]  dbus,
  input logic [N-1:0] strobe
);

  ack_single: assert property (@(posedge clk) disable iff (!rst_n) xfer_ack |=> !xfer_ack);
  err_qual:   assert property (@(posedge clk) disable iff (!rst_n) err_ack |-> xfer_ack);
  dbus_idle:  assert property (@(posedge clk) disable iff (!rst_n) !xfer_ack |-> (dbus == 32'h0));
  commit_all: assert property (@(posedge clk) disable iff (!rst_n) commit |-> (&strobe));

endmodule

module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR    = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter int          C_NUM_REGS    = 4,
  parameter int          C_SHADOWED    = 0,
  parameter logic [31:0] C_RESET_VALUE = 32'h0000_0000
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_wr_strobe,
  output logic                      user_commit
);

  localparam logic [31:0] SPAN     = C_HIGHADDR - C_BASEADDR;
  localparam logic [29:0] NUM_W    = 30'(C_NUM_REGS);
  localparam bit          SHADOWED = (C_SHADOWED != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t state_r;
  state_t state_s;

  logic [31:0] addr_s;
  logic [31:0] offset_s;
  logic [31:0] wdata_s;
  logic [29:0] word_s;
  logic        hit_s;
  logic        mapped_s;
  logic        commit_word_s;
  logic        capture_s;
  logic        do_write_s;
  logic        do_commit_s;
  logic [31:0] rd_word_s;

  logic [31:0] reg_r    [C_NUM_REGS];
  logic [31:0] shadow_r [C_NUM_REGS];

  logic                  rnw_r;
  logic                  mapped_r;
  logic                  commit_word_r;
  logic [4:0]            widx_r;
  logic [31:0]           dbus_r;
  logic                  xfer_ack_r;
  logic                  err_ack_r;
  logic                  commit_r;
  logic [C_NUM_REGS-1:0] strobe_r;
  logic                  unused_s;

  // Byte-lane merge: BE[0] selects the most significant byte of the word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [0:3]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[31-8*b -: 8] = new_v[31-8*b -: 8];
      end else begin
        res[31-8*b -: 8] = old_v[31-8*b -: 8];
      end
    end
    return res;
  endfunction

  assign addr_s        = OPB_ABus;
  assign wdata_s       = OPB_DBus;
  // Subtracting the base first lets a single unsigned compare cover both window edges.
  assign offset_s      = addr_s - C_BASEADDR;
  assign word_s        = offset_s[31:2];
  assign hit_s         = OPB_select && (offset_s <= SPAN);
  assign mapped_s      = (word_s < NUM_W);
  assign commit_word_s = SHADOWED && (word_s == NUM_W);
  assign capture_s     = (state_r == ST_IDLE) && hit_s;
  assign do_write_s    = (state_r == ST_ACK) && !rnw_r && mapped_r;
  assign do_commit_s   = (state_r == ST_ACK) && !rnw_r && commit_word_r && wdata_s[0] && OPB_BE[3];
  assign unused_s      = &{1'b0, OPB_seqAddr, offset_s[1:0]};

  // Read-data mux: software sees the shadow copy when shadowing is enabled.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      rd_word_s = rd_word_s |
                  ((word_s == 30'(k)) ? (SHADOWED ? shadow_r[k] : reg_r[k]) : 32'h0000_0000);
    end
  end

  // Transfer FSM state register.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Transfer FSM next state; HOLD swallows the cycle in which the master drops select.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hit_s) begin
          state_s = ST_ACK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACK:  state_s = ST_HOLD;
      ST_HOLD: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Capture the decoded request on a hit so the ACK cycle does not depend on a live decode.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      rnw_r         <= 1'b0;
      mapped_r      <= 1'b0;
      commit_word_r <= 1'b0;
      widx_r        <= 5'd0;
    end else if (capture_s) begin
      rnw_r         <= OPB_RNW;
      mapped_r      <= mapped_s;
      commit_word_r <= commit_word_s;
      widx_r        <= word_s[4:0];
    end else begin
      rnw_r         <= rnw_r;
      mapped_r      <= mapped_r;
      commit_word_r <= commit_word_r;
      widx_r        <= widx_r;
    end
  end

  // Registered OPB response: ack, error and read data appear in the cycle after the hit.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      xfer_ack_r <= 1'b0;
      err_ack_r  <= 1'b0;
      dbus_r     <= 32'h0000_0000;
    end else if (capture_s) begin
      xfer_ack_r <= 1'b1;
      err_ack_r  <= !mapped_s && !commit_word_s;
      dbus_r     <= (OPB_RNW && mapped_s) ? rd_word_s : 32'h0000_0000;
    end else begin
      xfer_ack_r <= 1'b0;
      err_ack_r  <= 1'b0;
      dbus_r     <= 32'h0000_0000;
    end
  end

  // Register bank, shadows, per-word strobes and the commit pulse.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      for (int k = 0; k < C_NUM_REGS; k++) begin
        reg_r[k]    <= C_RESET_VALUE;
        shadow_r[k] <= C_RESET_VALUE;
      end
      strobe_r <= {C_NUM_REGS{1'b0}};
      commit_r <= 1'b0;
    end else begin
      strobe_r <= {C_NUM_REGS{1'b0}};
      commit_r <= do_commit_s;
      for (int k = 0; k < C_NUM_REGS; k++) begin
        if (do_commit_s) begin
          reg_r[k]    <= shadow_r[k];
          strobe_r[k] <= 1'b1;
        end else if (do_write_s && (widx_r == 5'(k))) begin
          // Immediate mode strobes even when no byte lane is enabled.
          if (SHADOWED) begin
            shadow_r[k] <= merge_bytes(shadow_r[k], wdata_s, OPB_BE);
          end else begin
            reg_r[k]    <= merge_bytes(reg_r[k], wdata_s, OPB_BE);
            strobe_r[k] <= 1'b1;
          end
        end else begin
          reg_r[k]    <= reg_r[k];
          shadow_r[k] <= shadow_r[k];
        end
      end
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = reg_r[g];
  end

  assign Sl_DBus        = dbus_r;
  assign Sl_xferAck     = xfer_ack_r;
  assign Sl_errAck      = err_ack_r;
  assign Sl_retry       = 1'b0;
  assign Sl_toutSup     = 1'b0;
  assign user_wr_strobe = strobe_r;
  assign user_commit    = commit_r;

  opb_register_bank_ppc2simulink_chk #(
    .N(C_NUM_REGS)
  ) u_chk (
    .clk      (OPB_Clk),
    .rst_n    (OPB_Rst_n),
    .xfer_ack (xfer_ack_r),
    .err_ack  (err_ack_r),
    .commit   (commit_r),
    .dbus     (dbus_r),
    .strobe   (strobe_r)
  );

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for opb_register_bank_ppc2simulink: one immediate-mode and one shadowed instance,
// directed test-plan steps then random transfers against an array-based register model.

module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] RST_VAL = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [0:31] abus;
  logic [0:31] dbus;
  logic [0:3]  be;
  logic        rnw;
  logic        seq_addr;
  logic [1:0]  sel;

  logic [0:31]  i_rd, s_rd;
  logic         i_ack, s_ack, i_err, s_err, i_retry, s_retry, i_tout, s_tout, i_cmt, s_cmt;
  logic [127:0] i_udo, s_udo;
  logic [3:0]   i_stb, s_stb;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_reg [2][4];
  logic [31:0] m_shd [4];

  opb_register_bank_ppc2simulink #(
    .C_NUM_REGS(4), .C_SHADOWED(0), .C_RESET_VALUE(RST_VAL)
  ) dut_imm (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel[0]), .OPB_seqAddr(seq_addr),
    .Sl_DBus(i_rd), .Sl_xferAck(i_ack), .Sl_errAck(i_err), .Sl_retry(i_retry),
    .Sl_toutSup(i_tout), .user_data_out(i_udo), .user_wr_strobe(i_stb), .user_commit(i_cmt)
  );

  opb_register_bank_ppc2simulink #(
    .C_NUM_REGS(4), .C_SHADOWED(1), .C_RESET_VALUE(RST_VAL)
  ) dut_shd (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel[1]), .OPB_seqAddr(seq_addr),
    .Sl_DBus(s_rd), .Sl_xferAck(s_ack), .Sl_errAck(s_err), .Sl_retry(s_retry),
    .Sl_toutSup(s_tout), .user_data_out(s_udo), .user_wr_strobe(s_stb), .user_commit(s_cmt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] m_udo(input int d);
    return {m_reg[d][3], m_reg[d][2], m_reg[d][1], m_reg[d][0]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) for (int k = 0; k < 4; k++) m_reg[d][k] = RST_VAL;
    for (int k = 0; k < 4; k++) m_shd[k] = RST_VAL;
  endtask

  // One OPB transfer to instance d, started at a negedge in IDLE; ends at a negedge in IDLE.
  // hold_long keeps select asserted through the HOLD cycle like a sluggish master.
  task automatic xfer(input int d, input bit rd, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] ben, input bit hold_long);
    int          w;
    bit          shd, mapped, is_cmt, exp_err, exp_cmt;
    logic [31:0] exp_rd, mask;
    logic [3:0]  exp_stb;
    shd     = (d == 1);
    w       = int'(addr >> 2);
    mapped  = (w < 4);
    is_cmt  = shd && (w == 4);
    exp_err = !mapped && !is_cmt;
    exp_rd  = 32'h0;
    if (rd && mapped) exp_rd = shd ? m_shd[w] : m_reg[d][w];
    abus = addr; dbus = data; be = ben; rnw = rd; sel[d] = 1'b1;
    @(negedge clk);
    chk("ack_cycle1", shd ? s_ack : i_ack, 1'b1);
    chk("err_ack", shd ? s_err : i_err, exp_err);
    if (rd) chk("read_data", shd ? s_rd : i_rd, exp_rd);
    exp_stb = 4'h0;
    exp_cmt = 1'b0;
    mask    = 32'h0;
    for (int j = 0; j < 4; j++) if (ben[j]) mask[8*j +: 8] = 8'hFF;
    if (!rd && mapped) begin
      if (shd) m_shd[w] = (m_shd[w] & ~mask) | (data & mask);
      else begin
        m_reg[d][w] = (m_reg[d][w] & ~mask) | (data & mask);
        exp_stb = 4'(1 << w);
      end
    end
    if (!rd && is_cmt && data[0] && ben[0]) begin
      for (int k = 0; k < 4; k++) m_reg[1][k] = m_shd[k];
      exp_stb = 4'hF;
      exp_cmt = 1'b1;
    end
    @(negedge clk);
    if (!hold_long) sel[d] = 1'b0;
    chk("ack_hold", shd ? s_ack : i_ack, 1'b0);
    chk("dbus_hold", shd ? s_rd : i_rd, 32'h0);
    chk("strobe", shd ? s_stb : i_stb, exp_stb);
    chk("commit", shd ? s_cmt : i_cmt, exp_cmt);
    chk("user_data", shd ? s_udo : i_udo, m_udo(d));
    @(negedge clk);
    sel[d] = 1'b0;
    chk("no_reack", shd ? s_ack : i_ack, 1'b0);
  endtask

  // Select outside the window must never be acknowledged.
  task automatic nohit(input int d, input logic [31:0] addr);
    abus = addr; rnw = 1'b1; sel[d] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("nohit_ack", (d == 1) ? s_ack : i_ack, 1'b0);
    end
    sel[d] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d, w;
    bit          rd, hl;
    logic [31:0] a;

    rst_n = 1'b0; sel = 2'b00; abus = 32'h0; dbus = 32'h0; be = 4'h0; rnw = 1'b0; seq_addr = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_udo_imm", i_udo, {4{RST_VAL}});
    chk("rst_udo_shd", s_udo, {4{RST_VAL}});
    chk("rst_ack", {i_ack, s_ack, i_err, s_err}, 4'h0);
    chk("rst_dbus", {i_rd, s_rd}, 64'h0);
    chk("rst_misc", {i_retry, s_retry, i_tout, s_tout, i_cmt, s_cmt}, 6'h0);
    chk("rst_stb", {i_stb, s_stb}, 8'h0);
    rst_n = 1'b1;
    @(negedge clk);

    xfer(0, 1'b0, 32'h8, 32'h1234_5678, 4'hF, 1'b0);
    chk("word2_bits", i_udo[95:64], 32'h1234_5678);
    xfer(0, 1'b1, 32'h8, 32'h0, 4'hF, 1'b0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
    xfer(0, 1'b0, 32'h0, 32'hFFFF_FFFF, 4'b0101, 1'b0);
    chk("be_0101", i_udo[31:0], 32'h00FF_00FF);
    xfer(0, 1'b1, 32'h0, 32'h0, 4'hF, 1'b0);
    xfer(0, 1'b0, 32'h4, 32'hCAFE_F00D, 4'h0, 1'b0);

    xfer(1, 1'b0, 32'h0, 32'h1, 4'hF, 1'b0);
    xfer(1, 1'b0, 32'h4, 32'h2, 4'hF, 1'b0);
    chk("shadow_hidden", s_udo, {4{RST_VAL}});
    xfer(1, 1'b1, 32'h0, 32'h0, 4'hF, 1'b0);
    xfer(1, 1'b1, 32'h4, 32'h0, 4'hF, 1'b0);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
    xfer(1, 1'b0, 32'h10, 32'h1, 4'hE, 1'b0);
    xfer(1, 1'b0, 32'h10, 32'h1, 4'hF, 1'b0);
    chk("commit_words", s_udo[63:0], {32'h2, 32'h1});
    xfer(1, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0);

    xfer(0, 1'b1, 32'h40, 32'h0, 4'hF, 1'b0);
    xfer(0, 1'b0, 32'h10, 32'h5555_AAAA, 4'hF, 1'b0);
    xfer(1, 1'b0, 32'hFC, 32'h5555_AAAA, 4'hF, 1'b0);
    xfer(0, 1'b1, 32'h8, 32'h0, 4'hF, 1'b1);
    nohit(0, 32'h100);
    nohit(1, 32'hFFFF_FFF0);

    abus = 32'h4; dbus = 32'hDEAD_BEEF; be = 4'hF; rnw = 1'b0; sel[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_ack", i_ack, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    sel[0] = 1'b0;
    rst_n  = 1'b1;
    model_reset();
    chk("mid_rst_ack_clr", i_ack, 1'b0);
    chk("mid_rst_word1", i_udo[63:32], RST_VAL);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_noack", {i_ack, i_stb}, 5'h0);
    end
    chk("post_rst_udo", i_udo, m_udo(0));

    for (int n = 0; n < 300; n++) begin
      d  = int'($urandom_range(0, 1));
      w  = int'($urandom_range(0, 7));
      if (w == 7) w = 63;
      a  = 32'(w * 4) + 32'($urandom_range(0, 3));
      rd = 1'($urandom_range(0, 1));
      hl = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) nohit(d, 32'h100 + 32'($urandom_range(0, 255)));
      else xfer(d, rd, a, $urandom, 4'($urandom_range(0, 15)), hl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
